// File: rtl/ifexp_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// ifexp compare/select arbiter.
package ifexp_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_NBITS = 8;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 16;

  // One-hot grant: first set bit of req searching ptr, ptr+1, ... modulo nreq.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] req,
    input int unsigned         ptr,
    input int unsigned         nreq
  );
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    int unsigned         idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      idx = ptr + i;
      if (idx >= nreq) idx = idx - nreq;
      if ((i < nreq) && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/ifexp_sel.sv
// Combinational compare/select: DATA = (A > B) ? A : B + 1, unsigned,
// with B + 1 wrapping at the operand width.
module ifexp_sel #(
  parameter int NBITS = ifexp_pkg::DEF_NBITS
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic [NBITS-1:0] data,
  output logic             sel
);

  assign sel  = (a > b);
  assign data = sel ? a : b + 1'b1;

endmodule

// File: rtl/ifexp_arbiter.sv
// Round-robin arbiter feeding a shared 2-stage compare/select pipeline,
// with valid/ready on both sides and a flush FSM that drains the pipe.
module ifexp_arbiter
  import ifexp_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ*NBITS-1:0] REQ_A,
  input  logic [NREQ*NBITS-1:0] REQ_B,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [NBITS-1:0]      OUT_DATA,
  output logic [IDW-1:0]        OUT_ID,
  output logic                  OUT_SEL,
  input  logic                  FLUSH,
  output logic                  FLUSH_DONE,
  output logic                  BUSY
);

  state_e           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;

  logic             s1_v;
  logic [NBITS-1:0] s1_a, s1_b;
  logic [IDW-1:0]   s1_id;

  logic             s2_v;
  logic [NBITS-1:0] s2_data;
  logic             s2_sel;
  logic [IDW-1:0]   s2_id;

  logic             adv1, adv2;
  logic             grant_en, grant_any, flush_done;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic [NBITS-1:0] sel_data;
  logic             sel_gt;

  // A stage may load when it is empty or its content moves on this cycle.
  assign adv2 = !s2_v || OUT_READY;
  assign adv1 = !s1_v || adv2;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        if (FLUSH) state_nxt = DRAIN;
        else       grant_en  = adv1;
      end
      DRAIN: begin
        if (!s1_v && !s2_v) state_nxt = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    grant    = grant_en ? NREQ'(rr_pick(MAX_NREQ'(REQ_VALID), 32'(ptr), NREQ)) : '0;
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
    grant_any = |grant;
    ptr_nxt   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  ifexp_sel #(.NBITS(NBITS)) u_sel (
    .a    (s1_a),
    .b    (s1_b),
    .data (sel_data),
    .sel  (sel_gt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      ptr     <= '0;
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_id   <= '0;
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_sel  <= 1'b0;
      s2_id   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) ptr <= ptr_nxt;
      if (adv1) begin
        s1_v <= grant_any;
        if (grant_any) begin
          s1_a  <= REQ_A[grant_id*NBITS +: NBITS];
          s1_b  <= REQ_B[grant_id*NBITS +: NBITS];
          s1_id <= grant_id;
        end
      end
      // S2 payload only changes on a real transfer, keeping the output stable when idle.
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_data <= sel_data;
          s2_sel  <= sel_gt;
          s2_id   <= s1_id;
        end
      end
    end
  end

  assign REQ_READY  = grant;
  assign OUT_VALID  = s2_v;
  assign OUT_DATA   = s2_data;
  assign OUT_ID     = s2_id;
  assign OUT_SEL    = s2_sel;
  assign FLUSH_DONE = flush_done;
  assign BUSY       = s1_v || s2_v;

endmodule

// File: tb/tb_ifexp_arbiter.sv
// Self-checking bench for ifexp_arbiter: directed scenarios plus random
// traffic, checked against a queue-based behavioural model.
module tb_ifexp_arbiter;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NB-1:0]    req_a [NR];
  logic [NB-1:0]    req_b [NR];
  logic [NR*NB-1:0] req_a_p, req_b_p;
  logic             out_valid, out_ready, out_sel, flush, flush_done, busy;
  logic [NB-1:0]    out_data;
  logic [IW-1:0]    out_id;

  always #5 clk = ~clk;

  always_comb begin
    req_a_p = '0;
    req_b_p = '0;
    for (int i = 0; i < NR; i++) begin
      req_a_p[i*NB +: NB] = req_a[i];
      req_b_p[i*NB +: NB] = req_b[i];
    end
  end

  ifexp_arbiter #(.NBITS(NB), .NREQ(NR)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_A      (req_a_p),
    .REQ_B      (req_b_p),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .OUT_DATA   (out_data),
    .OUT_ID     (out_id),
    .OUT_SEL    (out_sel),
    .FLUSH      (flush),
    .FLUSH_DONE (flush_done),
    .BUSY       (busy)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [NB-1:0] data;
    logic          sel;
    logic [IW-1:0] id;
  } res_t;

  res_t        q[$];       // accepted, not yet consumed, oldest first
  bit          head_out;   // oldest entry has reached the output
  int          ptr = 0;
  int          mst = 0;    // 0 run, 1 drain, 2 done
  int          last_g = -1;
  int          g_now;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [NR-1:0] exp_ready;
  bit          exp_valid, exp_done, exp_busy;
  res_t        exp_res;

  function automatic res_t ref_result(int a, int b, int id);
    res_t r;
    r.sel  = (a > b);
    r.data = (a > b) ? NB'(a) : NB'((b + 1) % 256);
    r.id   = IW'(id);
    return r;
  endfunction

  task automatic model_eval();
    bit adv1;
    adv1  = (q.size() < 2) || out_ready;
    g_now = -1;
    if (mst == 0 && !flush && adv1) begin
      for (int i = 0; i < NR; i++) begin
        int idx;
        idx = (ptr + i) % NR;
        if (g_now < 0 && req_valid[idx]) g_now = idx;
      end
    end
    exp_ready = (g_now >= 0) ? NR'(1 << g_now) : '0;
    exp_valid = head_out;
    exp_res   = head_out ? q[0] : '0;
    exp_done  = (mst == 2);
    exp_busy  = (q.size() != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_eval();
    if (rst) begin
      q.delete();
      head_out = 0;
      ptr      = 0;
      mst      = 0;
      last_g   = -1;
    end else begin
      int n0;
      bit ho;
      n0 = q.size();
      if (head_out && out_ready) void'(q.pop_front());
      ho = (q.size() > 0);
      if (g_now >= 0) begin
        q.push_back(ref_result(int'(req_a[g_now]), int'(req_b[g_now]), g_now));
        ptr = (g_now + 1) % NR;
      end
      head_out = ho;
      last_g   = g_now;
      case (mst)
        0: if (flush) mst = 1;
        1: if (n0 == 0) mst = 2;
        default: mst = 0;
      endcase
    end
    cyc++;
    #1;
  endtask

  function automatic logic [17:0] obs_vec();
    return {req_ready, out_valid, exp_valid ? {out_data, out_id, out_sel} : 11'd0, flush_done, busy};
  endfunction

  function automatic logic [17:0] exp_vec();
    return {exp_ready, exp_valid, exp_valid ? {exp_res.data, exp_res.id, exp_res.sel} : 11'd0,
            exp_done, exp_busy};
  endfunction

  task automatic refresh(int pv);
    for (int i = 0; i < NR; i++) begin
      if (!req_valid[i] || i == last_g) begin
        req_valid[i] = ($urandom_range(99) < pv);
        req_a[i]     = NB'($urandom);
        case ($urandom_range(7))
          0:       req_b[i] = req_a[i];
          1:       req_b[i] = 8'hff;
          default: req_b[i] = NB'($urandom);
        endcase
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; req_valid = '0;
    for (int i = 0; i < NR; i++) begin req_a[i] = '0; req_b[i] = '0; end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, out_valid, out_data, out_id, out_sel, flush_done, busy} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {req_ready, out_valid, out_data, out_id, out_sel, flush_done, busy});
    end
    tick();
  endtask

  task automatic test_round_robin();
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b1; req_a[i] = NB'($urandom); req_b[i] = NB'($urandom);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr_model cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (req_ready !== NR'(1 << (k % NR))) begin
        miscompares++;
        $display("FAIL rr_order k=%0d: got %b expected %b", k, req_ready, NR'(1 << (k % NR)));
      end
      tick();
      if (last_g >= 0) begin
        req_a[last_g] = NB'($urandom); req_b[last_g] = NB'($urandom);
      end
    end
    req_valid = '0;
    repeat (3) begin
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr_drain cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_compute();
    int ta [5] = '{10, 3, 5, 0, 255};
    int tb [5] = '{3, 10, 5, 255, 254};
    int td [5] = '{10, 11, 6, 0, 255};
    int ts [5] = '{1, 0, 0, 0, 1};
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      req_valid = 4'b0001; req_a[0] = NB'(ta[t]); req_b[0] = NB'(tb[t]);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        model_eval();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL compute_model cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
        end
        if (k == 2) begin
          vectors++;
          if ({out_valid, out_data, out_sel, out_id} !== {1'b1, NB'(td[t]), ts[t][0], 2'd0}) begin
            miscompares++;
            $display("FAIL compute A=%0d B=%0d: got v=%b d=%0d s=%b id=%0d expected d=%0d s=%0d id=0",
                     ta[t], tb[t], out_valid, out_data, out_sel, out_id, td[t], ts[t]);
          end
        end
        tick();
        req_valid = '0;
      end
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    out_ready = 1'b0;
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin req_a[i] = NB'($urandom); req_b[i] = NB'($urandom); end
    for (int k = 0; k < 15; k++) begin
      out_ready = (k >= 7);
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_model cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      if (k >= 2 && k < 7) begin
        vectors++;
        if ({req_ready, busy, out_valid} !== {4'b0000, 1'b1, 1'b1}) begin
          miscompares++;
          $display("FAIL bp_stall k=%0d: got ready=%b busy=%b valid=%b expected 0000 1 1",
                   k, req_ready, busy, out_valid);
        end
      end
      if (out_valid && out_ready) hs++;
      tick();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    vectors++;
    if (hs !== 3) begin
      miscompares++;
      $display("FAIL bp_result_count: got %0d expected 3", hs);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    req_valid = 4'b0110;
    for (int i = 1; i < 3; i++) begin req_a[i] = NB'($urandom); req_b[i] = NB'($urandom); end
    for (int k = 0; k < 12; k++) begin
      flush     = (k == 2);
      out_ready = (k >= 3);
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL flush_model cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (flush_done !== (k == 6)) begin
        miscompares++;
        $display("FAIL flush_done_timing k=%0d: got %b expected %b", k, flush_done, (k == 6));
      end
      if (k >= 2 && k <= 6) begin
        vectors++;
        if (req_ready !== '0) begin
          miscompares++;
          $display("FAIL flush_no_grant k=%0d: got %b expected 0000", k, req_ready);
        end
      end
      tick();
      if (last_g >= 0) begin
        req_a[last_g] = NB'($urandom); req_b[last_g] = NB'($urandom);
      end
    end
    flush = 1'b0; req_valid = '0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL flush_tail cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_flush_empty();
    req_valid = '0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      flush = (k == 0);
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL flush_empty_model cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (flush_done !== (k == 2)) begin
        miscompares++;
        $display("FAIL flush_empty_done k=%0d: got %b expected %b", k, flush_done, (k == 2));
      end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin req_a[i] = NB'($urandom); req_b[i] = NB'($urandom); end
    for (int k = 0; k < 10; k++) begin
      rst = (k == 3);
      if (k == 4) begin
        req_valid = 4'b1100;
        req_a[2] = 8'd7; req_b[2] = 8'd9;
      end
      out_ready = (k >= 5);
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rstmid_model cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      if (k == 4) begin
        vectors++;
        if ({out_valid, out_data, out_id, out_sel, flush_done, busy, req_ready}
            !== {14'd0, 4'b0100}) begin
          miscompares++;
          $display("FAIL rstmid_after v=%b d=%0d id=%0d s=%b fd=%b busy=%b ready=%b expected zeros, ready 0100",
                   out_valid, out_data, out_id, out_sel, flush_done, busy, req_ready);
        end
      end
      tick();
      if (k >= 4 && last_g >= 0) req_valid[last_g] = 1'b0;
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(39) == 0);
      rst       = ($urandom_range(199) == 0);
      refresh(60);
      @(negedge clk);
      model_eval();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_compute();
    test_backpressure();
    test_flush();
    test_flush_empty();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifexp_arbiter.md
Name: ifexp_arbiter

Overview:
- Shares one compare/select unit, OUT = (A > B) ? A : B + 1, between NREQ requesters.
- Arbitration is round-robin. The datapath is a 2-stage pipeline with valid/ready handshakes on both sides.
- Each result carries the requester ID.
- A flush FSM drains the pipe on demand.
- Sits between operand producers and a single result consumer.

Parameters:
- NBITS, 8, operand/result width (unsigned).
- NREQ, 4, number of requesters (2..16).
- IDW, max(1, clog2(NREQ)), requester ID width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  NREQ  per-requester operand valid.
- REQ_READY  out  NREQ  per-requester accept; one-hot or zero.
- REQ_A  in  NREQ*NBITS  packed A operands; requester i at bits [i*NBITS +: NBITS].
- REQ_B  in  NREQ*NBITS  packed B operands; same packing as REQ_A.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accept.
- OUT_DATA  out  NBITS  selected result.
- OUT_ID  out  IDW  index of the originating requester.
- OUT_SEL  out  1  1 = A chosen (A > B), 0 = B+1 chosen.
- FLUSH  in  1  request drain; level-sensitive, sampled in RUN.
- FLUSH_DONE  out  1  one-cycle pulse when the drain completes.
- BUSY  out  1  any pipeline stage valid.

Behaviour:
- Reset: one clock with RST=1. All outputs go to 0: REQ_READY=0, OUT_VALID=0, OUT_DATA=0, OUT_ID=0, OUT_SEL=0, FLUSH_DONE=0, BUSY=0. RR pointer=0, FSM=RUN, stage valids=0.
- Reset mid-transaction discards in-flight data; no result emerges.
- Stage 1 (S1) registers {A, B, ID}. Stage 2 (S2) registers {DATA, SEL, ID}. The outputs are driven from S2.
- Pipeline advance: adv2 = !S2.v | OUT_READY; adv1 = !S1.v | adv2. Bubbles collapse.
- Throughput: 1 result/cycle when unstalled.
- Latency: accept at edge t gives OUT_VALID from t+2 (after the edge).
- Arbitration is combinational from REQ_VALID, the pointer and adv1.
- Grant rule, in FSM RUN with adv1=1: grant the first valid requester searching ptr, ptr+1, ..., wrapping modulo NREQ. REQ_READY[g]=1 for the granted requester only.
- REQ_READY never asserts without the matching REQ_VALID.
- On a grant g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Producers must hold operands stable while VALID=1 and READY=0.
- Compute, S1 to S2: SEL = (A > B), unsigned compare.
- DATA = SEL ? A : (B + 1) truncated to NBITS, so B = 2^NBITS-1 wraps to 0.
- A == B gives SEL=0 and DATA = B+1.
- S2 holds DATA/ID/SEL stable while OUT_VALID=1 and OUT_READY=0.
- FSM states: RUN, DRAIN, DONE.
- RUN: on FLUSH=1, go to DRAIN. No grant occurs in the cycle FLUSH is sampled.
- DRAIN: REQ_READY=0 and the pipe continues to advance. When S1.v=0 and S2.v=0 (after the last handshake), go to DONE.
- DONE: FLUSH_DONE=1 for exactly this cycle; go to RUN next cycle.
- If FLUSH is still high in RUN, a new drain begins immediately (zero-grant).
- Flush with an already empty pipe: RUN, DRAIN, DONE, giving FLUSH_DONE 2 cycles after FLUSH is sampled.
- BUSY = S1.v | S2.v.
- Simultaneous FLUSH and RST: reset wins.

Decomposition:
- Package ifexp_pkg holds:
  - state enum {RUN, DRAIN, DONE};
  - the default constants NBITS=8 and NREQ=4;
  - an rr_pick function (one-hot grant from a request vector and pointer).
- Sub-module ifexp_sel: combinational A, B to DATA, SEL per the compare rule, NBITS parameter.
- The arbiter, pipeline and FSM live in ifexp_arbiter.

Test Plan:
1. Single requester, OUT_READY=1: REQ0 A=10, B=3. Expect OUT_DATA=10, SEL=1, ID=0, two cycles after accept. Then A=3, B=10: expect 11, SEL=0.
2. Boundaries: A=5, B=5 gives 6, SEL=0. A=0, B=255 gives 0 (wrap), SEL=0. A=255, B=254 gives 255, SEL=1.
3. All 4 requesters valid continuously, OUT_READY=1: grants go 0,1,2,3,0,... OUT_ID follows the same sequence at one result per cycle. Each REQ_READY is high 1 cycle in 4.
4. Backpressure: 3 requests in flight, OUT_READY=0 for 5 cycles. Expect OUT_DATA/ID held, no REQ_READY once S1 and S2 are full. Release gives 3 results in order with no loss or duplicate.
5. Flush with REQ1 and REQ2 valid and 2 items in the pipe: expect no new grants, both items drained, FLUSH_DONE pulse 1 cycle after the last handshake, then grants resume from the saved ptr.
6. RST asserted while S1.v=S2.v=1: next cycle all outputs 0, no stale OUT_VALID, ptr=0. The first grant after reset goes to the lowest valid index.
